// File: rtl/ama_riscv_uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package ama_riscv_uart_rx_pkg;

    // Width of one UART data character.
    localparam int UART_BYTE_W = 8;

    // Receive state machine states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // Core clock cycles per serial bit.
    function automatic int bit_ticks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/ama_riscv_uart_rx_if.sv
// Ready/valid byte stream. TX is the producer side, RX the consumer side.
interface ama_riscv_uart_rx_if #(
    parameter int DW = 8
);

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    // Producer: presents valid/data, observes ready.
    modport TX (
        output valid,
        output data,
        input  ready
    );

    // Consumer: observes valid/data, drives ready.
    modport RX (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/ama_riscv_uart_rx_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra MSB so that full and
// empty are distinguishable without a separate occupancy counter. A push
// into a full FIFO is accepted when a pop happens in the same cycle.
module ama_riscv_uart_rx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head entry is forced to zero when nothing is buffered.
    assign o_head = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Read/write pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which
        // entries are valid, and the head mux hides stale contents.
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/ama_riscv_uart_rx.sv
// UART receiver: 8N1 deserialiser with a small receive FIFO and
// framing-error / overrun pulses. The line is synchronised, falling edges
// start a frame, the start bit is re-checked at mid-bit, data and stop
// bits are sampled at their centres.
module ama_riscv_uart_rx
    import ama_riscv_uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    ama_riscv_uart_rx_if.TX       recv_rsp,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int BIT_T  = bit_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_T = BIT_T / 2;
    localparam int CNT_W  = $clog2(BIT_T);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_T - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_T - 1);

    // Input conditioning
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync_prev;
    logic [1:0] r_warm;
    logic       r_armed;
    logic       w_fall;

    // Receive FSM
    uart_rx_state_t         r_state;
    uart_rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_nxt;
    logic [UART_BYTE_W-1:0] r_shift;
    logic [UART_BYTE_W-1:0] w_shift_nxt;
    logic                   r_frame_err;
    logic                   w_frame_err_nxt;
    logic                   r_overrun;
    logic                   w_overrun_nxt;

    // FIFO hookup
    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [UART_BYTE_W-1:0] w_fifo_head;

    // Synchroniser, edge history and arming. r_warm marks when r_sync2
    // holds a genuine line sample rather than its reset value, so a line
    // held low through reset never arms the edge detector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
            r_warm      <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sync1     <= serial_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_warm      <= {r_warm[0], 1'b1};
            r_armed     <= r_armed | (r_warm[1] & r_sync2);
        end
    end

    assign w_fall = r_armed && r_sync_prev && !r_sync2;

    // FSM, counters, shift register and status pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state, sampling and push decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path leaves a signal unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CNT_W'(1);
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_push          = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = START;
            end

            // Mid start bit: a high line means the edge was a glitch.
            START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_sync2) begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            // Data bits arrive LSB first; shift in from the top.
            DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[UART_BYTE_W-1:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = STOP;
                end
            end

            // Mid stop bit: deliver, drop or flag, then rearm immediately
            // so a back-to-back start edge is not missed.
            STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (!r_sync2) begin
                        w_frame_err_nxt = 1'b1;
                    end else if (!w_fifo_full || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_overrun_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_pop = !w_fifo_empty && recv_rsp.ready;

    ama_riscv_uart_rx_fifo #(
        .DW    (UART_BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    assign recv_rsp.valid = !w_fifo_empty;
    assign recv_rsp.data  = w_fifo_head;
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_ama_riscv_uart_rx.sv
// Bench for ama_riscv_uart_rx: frames are driven on serial_in, a
// frame-level model queues the expected bytes and status pulses, and an
// independent monitor compares whatever the receiver presents.
module tb_ama_riscv_uart_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_T    = CLK_FREQ / BAUD;
    localparam int DEPTH    = 4;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic serial_in = 1'b1;
    logic frame_err;
    logic overrun;

    int total        = 0;
    int bad          = 0;
    int cyc          = 0;
    int last_del_cyc = -1;

    logic [7:0] exp_bytes[$];
    logic [1:0] exp_flags[$];   // {frame_err, overrun}

    ama_riscv_uart_rx_if #(.DW(8)) rsp_if ();

    ama_riscv_uart_rx #(
        .CLOCK_FREQ (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .recv_rsp  (rsp_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame-level model: a good stop bit delivers the byte unless the
    // buffer already holds DEPTH bytes and the consumer does not take one
    // at the moment of the stop sample.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input bit pop_at_stop);
        if (!stop_ok)
            exp_flags.push_back(2'b10);
        else if (exp_bytes.size() < DEPTH || pop_at_stop)
            exp_bytes.push_back(b);
        else
            exp_flags.push_back(2'b01);
    endtask

    // Drive the first n bits of a start/data/stop sequence, one bit time
    // each, changing the line on negative clock edges.
    task automatic drive_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = bits[i];
            repeat (BIT_T) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
        model_frame(b, stop_bit, pop_at_stop);
        drive_bits({stop_bit, b, 1'b0}, 10);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_bytes.size() == 0 && exp_flags.size() == 0) break;
            @(negedge clk);
        end
        #2;
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        check({name, "_flags_left"}, exp_flags.size(), 0);
    endtask

    // Monitor: consumes expectations whenever the DUT transfers a byte or
    // raises a status pulse; also checks data stability under back-pressure.
    initial begin : monitor
        logic [7:0] held;
        logic       holding;
        logic [1:0] fl;
        logic [7:0] e;
        holding = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (holding && rsp_if.valid) check("data_stable", rsp_if.data, held);
            if (rsp_if.valid && rsp_if.ready) begin
                if (exp_bytes.size() == 0) begin
                    check("byte_unexpected", rsp_if.valid, 0);
                end else begin
                    e = exp_bytes.pop_front();
                    check("rx_byte", rsp_if.data, e);
                    last_del_cyc = cyc;
                end
            end
            holding = rsp_if.valid && !rsp_if.ready;
            held    = rsp_if.data;
            fl = {frame_err, overrun};
            if (fl != 2'b00) begin
                if (exp_flags.size() == 0) check("flag_unexpected", fl, 0);
                else                       check("flags", fl, exp_flags.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stimulus
        int t0;
        logic [7:0] b;
        bit err;
        int gap;

        rsp_if.ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid",     rsp_if.valid, 0);
        check("reset_data",      rsp_if.data, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun",   overrun, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // 1: single frame, latency from start edge to valid
        rsp_if.ready = 1'b1;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 0);
        repeat (20) @(negedge clk);
        check("t1_latency", last_del_cyc - t0, 98);
        wait_drain("t1");

        // 2: 3-cycle glitch, then a real frame shortly after
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        repeat (7) @(negedge clk);
        send_frame(8'h5C, 1'b1, 0);
        repeat (20) @(negedge clk);
        wait_drain("t2");

        // 3: bad stop bit
        send_frame(8'h3C, 1'b0, 0);
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        wait_drain("t3");

        // 4: overrun on the fifth byte, then drain in order
        rsp_if.ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        repeat (20) @(negedge clk);
        #1;
        check("t4_valid_held", rsp_if.valid, 1);
        check("t4_head",       rsp_if.data, 8'h01);
        @(negedge clk);
        rsp_if.ready = 1'b1;
        wait_drain("t4");

        // 5: reset mid-frame discards buffered and partial bytes
        rsp_if.ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        drive_bits({1'b1, 8'h77, 1'b0}, 5);
        rst       = 1'b0;
        serial_in = 1'b1;
        exp_bytes.delete();
        repeat (2) @(negedge clk);
        #1;
        check("t5_reset_valid", rsp_if.valid, 0);
        check("t5_reset_data",  rsp_if.data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        rsp_if.ready = 1'b1;
        send_frame(8'h5A, 1'b1, 0);
        repeat (20) @(negedge clk);
        wait_drain("t5");

        // 6: ready rises exactly in the fifth byte's stop-sample cycle
        rsp_if.ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'hC0 + 8'(i), 1'b1, 0);
        fork
            send_frame(8'hC5, 1'b1, 1);
            begin
                repeat (97) @(negedge clk);
                rsp_if.ready = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        wait_drain("t6");

        // 7: random bytes, occasional bad stop bits, random idle gaps
        rsp_if.ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            b   = 8'($urandom);
            err = ($urandom_range(0, 7) == 0);
            send_frame(b, !err, 0);
            serial_in = 1'b1;
            gap = err ? 3 + $urandom_range(0, 10) : $urandom_range(0, 12);
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        wait_drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
